// File: rtl/fetch_decode_stage.sv
// Fetch/decode front end: PC sequencing, ROM addressing, decode of the EX word, one-bubble redirects.
// Decode is combinational from imem_rdata; redirects cost one bubble; there is no backpressure.
module fetch_decode_stage (
  input  logic        clk,
  input  logic        rst_n,
  output logic [11:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall_F,
  input  logic [2:0]  pc_src,
  input  logic [31:0] jalr_base,
  output logic        stall_EX,
  output logic [2:0]  inst_type,
  output logic [6:0]  funct7,
  output logic [2:0]  funct3,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [11:0] immI,
  output logic [19:0] immU,
  output logic [31:0] pc_EX,
  output logic [31:0] pc_plus4_EX,
  output logic [31:0] instret
);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } inst_fields_t;

  localparam logic [2:0] SRC_BRANCH = 3'b001;
  localparam logic [2:0] SRC_JAL    = 3'b010;
  localparam logic [2:0] SRC_JALR   = 3'b011;

  state_t       state_q, state_d;
  logic [31:0]  pc_f_q, pc_f_d;
  logic [31:0]  pc_ex_q, pc_ex_d;
  logic [31:0]  instret_q, instret_d;

  inst_fields_t inst;
  logic [31:0]  imm_i_sext;
  logic [31:0]  imm_b_sext;
  logic [31:0]  imm_j_sext;
  logic [31:0]  jalr_sum;
  logic [31:0]  target;
  logic         redirect;

  // Field view and immediates of the word currently in EX.
  always_comb begin
    inst       = inst_fields_t'(imem_rdata);
    imm_i_sext = {{20{imem_rdata[31]}}, imem_rdata[31:20]};
    imm_b_sext = {{19{imem_rdata[31]}}, imem_rdata[31], imem_rdata[7],
                  imem_rdata[30:25], imem_rdata[11:8], 1'b0};
    imm_j_sext = {{11{imem_rdata[31]}}, imem_rdata[31], imem_rdata[19:12],
                  imem_rdata[20], imem_rdata[30:21], 1'b0};
  end

  always_comb begin
    inst_type = 3'b111;
    case (inst.opcode)
      7'b0110011: inst_type = 3'b000;
      7'b0010011: inst_type = 3'b001;
      7'b0110111: inst_type = 3'b010;
      7'b1110011: inst_type = 3'b011;
      7'b1100011: inst_type = 3'b100;
      7'b1101111: inst_type = 3'b101;
      7'b1100111: inst_type = 3'b110;
      default:    inst_type = 3'b111;
    endcase
  end

  assign funct7 = inst.funct7;
  assign funct3 = inst.funct3;
  assign rd     = inst.rd;
  assign rs1    = inst.rs1;
  assign rs2    = inst.rs2;
  assign immI   = imem_rdata[31:20];
  assign immU   = imem_rdata[31:12];

  assign stall_EX = (state_q != RUN);

  // Redirect target; the instruction in EX is both the branch/jump and the immediate source.
  always_comb begin
    redirect = 1'b0;
    target   = pc_ex_q;
    jalr_sum = jalr_base + imm_i_sext;
    if (stall_F && !stall_EX) begin
      case (pc_src)
        SRC_BRANCH: begin
          redirect = 1'b1;
          target   = pc_ex_q + imm_b_sext;
        end
        SRC_JAL: begin
          redirect = 1'b1;
          target   = pc_ex_q + imm_j_sext;
        end
        SRC_JALR: begin
          redirect = 1'b1;
          target   = {jalr_sum[31:2], 2'b00};
        end
        default: redirect = 1'b0;
      endcase
    end
  end

  // Fetch PC stays word aligned whatever the redirect arithmetic produced.
  always_comb begin
    pc_f_d = pc_f_q + 32'd4;
    if (redirect) begin
      pc_f_d = target;
    end
    pc_f_d[1:0] = 2'b00;
    pc_ex_d     = pc_f_q;
    instret_d   = stall_EX ? instret_q : instret_q + 32'd1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    state_d = RUN;
      RUN:     state_d = redirect ? FLUSH : RUN;
      FLUSH:   state_d = RUN;
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FILL;
      pc_f_q    <= 32'd0;
      pc_ex_q   <= 32'd0;
      instret_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_f_q    <= pc_f_d;
      pc_ex_q   <= pc_ex_d;
      instret_q <= instret_d;
    end
  end

  assign imem_addr   = pc_f_q[13:2];
  assign pc_EX       = pc_ex_q;
  assign pc_plus4_EX = pc_ex_q + 32'd4;
  assign instret     = instret_q;

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Bench for fetch_decode_stage: directed redirect walk, then random redirects and async resets vs a PC-trace model.
module tb_fetch_decode_stage;

  logic        clk;
  logic        rst_n;
  logic [11:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall_F;
  logic [2:0]  pc_src;
  logic [31:0] jalr_base;
  logic        stall_EX;
  logic [2:0]  inst_type;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [11:0] immI;
  logic [19:0] immU;
  logic [31:0] pc_EX;
  logic [31:0] pc_plus4_EX;
  logic [31:0] instret;

  fetch_decode_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .stall_F     (stall_F),
    .pc_src      (pc_src),
    .jalr_base   (jalr_base),
    .stall_EX    (stall_EX),
    .inst_type   (inst_type),
    .funct7      (funct7),
    .funct3      (funct3),
    .rd          (rd),
    .rs1         (rs1),
    .rs2         (rs2),
    .immI        (immI),
    .immU        (immU),
    .pc_EX       (pc_EX),
    .pc_plus4_EX (pc_plus4_EX),
    .instret     (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] rom [4096];
  always @(posedge clk) imem_rdata <= rom[imem_addr];

  int n_cmp = 0;
  int n_err = 0;

  // Reference: fetch PC, PC of the EX word, retired count, and whether EX holds a bubble.
  logic [31:0] m_pc_f, m_pc_ex, m_instret;
  bit          m_bub;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] exp_type(input logic [31:0] w);
    case (w[6:0])
      7'h33:   return 3'd0;
      7'h13:   return 3'd1;
      7'h37:   return 3'd2;
      7'h73:   return 3'd3;
      7'h63:   return 3'd4;
      7'h6F:   return 3'd5;
      7'h67:   return 3'd6;
      default: return 3'd7;
    endcase
  endfunction

  // Immediates as signed integers built from weighted instruction bits.
  function automatic int imm_i(input logic [31:0] w);
    return (w[31] ? -2048 : 0) + int'(w[30:20]);
  endfunction
  function automatic int imm_b(input logic [31:0] w);
    return (w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
  endfunction
  function automatic int imm_j(input logic [31:0] w);
    return (w[31] ? -1048576 : 0) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
  endfunction

  task automatic model_reset();
    m_pc_f    = 32'd0;
    m_pc_ex   = 32'd0;
    m_instret = 32'd0;
    m_bub     = 1'b1;
  endtask

  task automatic check_outputs();
    logic [31:0] w;
    w = rom[m_pc_ex[13:2]];
    check_eq("stall_EX",    {31'd0, stall_EX}, {31'd0, m_bub});
    check_eq("imem_addr",   {20'd0, imem_addr}, {20'd0, m_pc_f[13:2]});
    check_eq("pc_EX",       pc_EX, m_pc_ex);
    check_eq("pc_plus4_EX", pc_plus4_EX, m_pc_ex + 32'd4);
    check_eq("instret",     instret, m_instret);
    if (!m_bub) begin
      check_eq("inst_type", {29'd0, inst_type}, {29'd0, exp_type(w)});
      check_eq("fields",    {funct7, funct3, rd, rs1, rs2}, {7'd0, w[31:25], w[14:12], w[11:7], w[19:15], w[24:20]});
      check_eq("immI",      {20'd0, immI}, {20'd0, w[31:20]});
      check_eq("immU",      {12'd0, immU}, {12'd0, w[31:12]});
    end
  endtask

  // Advance the model across one rising edge using the inputs currently driven.
  task automatic model_step();
    logic [31:0] w, tgt;
    bit redir;
    w     = rom[m_pc_ex[13:2]];
    redir = !m_bub && stall_F && (pc_src == 3'd1 || pc_src == 3'd2 || pc_src == 3'd3);
    case (pc_src)
      3'd1:    tgt = m_pc_ex + 32'(imm_b(w));
      3'd2:    tgt = m_pc_ex + 32'(imm_j(w));
      default: tgt = jalr_base + 32'(imm_i(w));
    endcase
    m_pc_ex   = m_pc_f;
    m_pc_f    = redir ? (tgt & 32'hFFFF_FFFC) : m_pc_f + 32'd4;
    m_instret = m_instret + (m_bub ? 32'd0 : 32'd1);
    m_bub     = redir;
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_pc_EX"},     pc_EX, 32'd0);
    check_eq({tag, "_imem_addr"}, {20'd0, imem_addr}, 32'd0);
    check_eq({tag, "_stall_EX"},  {31'd0, stall_EX}, 32'd1);
    check_eq({tag, "_instret"},   instret, 32'd0);
  endtask

  // Called just after a falling edge; returns just after a falling edge with reset released.
  task automatic async_reset_pulse();
    #2 rst_n = 1'b0;
    #1 check_reset_values("async_rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [31:0] w;
    rst_n     = 1'b0;
    stall_F   = 1'b0;
    pc_src    = 3'd0;
    jalr_base = 32'd0;
    for (int i = 0; i < 4096; i++) rom[i] = $urandom;
    rom[0]    = 32'h0050_0093;  // addi x1, x0, 5
    rom[1]    = 32'h0000_0000;  // illegal opcode 0
    rom[2]    = 32'h0000_0863;  // beq x0, x0, +16 at 0x08
    rom[6]    = 32'h0000_8067;  // jalr x0, 0(x1) at 0x18
    rom[8]    = 32'hFE1F_F06F;  // jal x0, -32 at 0x20
    rom[64]   = 32'h0000_8067;  // jalr x0, 0(x1) at 0x100

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    #1 rst_n = 1'b1;
    model_reset();

    // Directed walk: 0 -> 8 (branch) -> 0x18 (jalr) -> 0x100 (jalr) -> 0x20 (jal) -> 0.
    for (int c = 0; c < 16; c++) begin
      check_outputs();
      stall_F   = 1'b0;
      pc_src    = 3'd0;
      jalr_base = 32'd0;
      if (m_bub) begin
        stall_F = 1'b1;
        pc_src  = 3'd1;
      end else if (m_pc_ex == 32'h4) begin
        stall_F = 1'b1;
        pc_src  = 3'd4;
      end else if (m_pc_ex == 32'h8) begin
        stall_F = 1'b1;
        pc_src  = 3'd1;
      end else if (m_pc_ex == 32'h18) begin
        stall_F   = 1'b1;
        pc_src    = 3'd3;
        jalr_base = 32'h103;
      end else if (m_pc_ex == 32'h100) begin
        stall_F   = 1'b1;
        pc_src    = 3'd3;
        jalr_base = 32'h20;
      end else if (m_pc_ex == 32'h20) begin
        stall_F = 1'b1;
        pc_src  = 3'd2;
      end
      model_step();
      @(posedge clk);
      @(negedge clk);
      if (c == 3) check_eq("branch_imem_addr", {20'd0, imem_addr}, 32'd6);
    end

    // Random redirects, occasional resets during bubbles, occasional jumps near the top of memory.
    for (int c = 0; c < 3000; c++) begin
      if (m_bub && $urandom_range(0, 5) == 0) begin
        async_reset_pulse();
      end else begin
        check_outputs();
        w         = rom[m_pc_ex[13:2]];
        stall_F   = $urandom_range(0, 1) == 1;
        pc_src    = 3'($urandom_range(0, 7));
        jalr_base = $urandom;
        if ($urandom_range(0, 7) == 0) jalr_base = 32'hFFFF_FFF0 - 32'(imm_i(w));
        model_step();
        @(posedge clk);
        @(negedge clk);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
